// File: rtl/maze_tiles_pkg.sv
// Shared maze geometry, tile/direction codes and game-state type used by the
// maze responder, the mover and the renderer.
package maze_tiles_pkg;

   localparam int MAZE_W = 28;
   localparam int MAZE_H = 31;
   localparam int ROW_W  = MAZE_W * 2;

   typedef enum logic [1:0] {
      WALL = 2'b00,
      WKNP = 2'b01,
      WKRP = 2'b10,
      WKGH = 2'b11
   } tile_t;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_UP    = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      GS_LOAD    = 2'b00,
      GS_PLAY    = 2'b01,
      GS_CLEARED = 2'b10
   } game_state_t;

   typedef logic [ROW_W-1:0] maze_row_t;

   // Number of walkable-with-pellet tiles in one packed row (tile x at bits 2x+1:2x).
   function automatic logic [5:0] wkrp_count(input maze_row_t row);
      logic [5:0] n;
      n = 6'd0;
      for (int x = 0; x < MAZE_W; x++) begin
         n = n + {5'd0, (row[2*x +: 2] == WKRP)};
      end
      return n;
   endfunction

endpackage

// File: rtl/maze_tiles_if.sv
// Mover <-> maze_tiles bundle: tile query and restart in, neighbour codes and
// game status out.
interface maze_tiles_if #(
   parameter int SCORE_W = 16
);
   logic               restart;
   logic [6:0]         curr_xtile;
   logic [6:0]         curr_ytile;
   logic [1:0]         tile_info [0:3];
   logic               ready;
   logic               level_clear;
   logic               pellet_eaten;
   logic [SCORE_W-1:0] score;
   logic [7:0]         pellets_left;

   modport master (
      output restart, curr_xtile, curr_ytile,
      input  tile_info, ready, level_clear, pellet_eaten, score, pellets_left
   );

   modport slave (
      input  restart, curr_xtile, curr_ytile,
      output tile_info, ready, level_clear, pellet_eaten, score, pellets_left
   );
endinterface

// File: rtl/maze_tiles_rom.sv
// Maze ROM: combinational row lookup returning one packed row of tile codes.
// Legend: '#' wall, '.'/'o' pellet, 'G' ghost house, ' ' empty floor.
module maze_tiles_rom
   import maze_tiles_pkg::*;
(
   input  logic [4:0] i_row,
   output maze_row_t  o_tiles
);

   logic [8*MAZE_W-1:0] w_text;

   function automatic maze_row_t decode_row(input logic [8*MAZE_W-1:0] s);
      maze_row_t  r;
      logic [7:0] c;
      r = {ROW_W{1'b0}};
      for (int x = 0; x < MAZE_W; x++) begin
         c = s[8*(MAZE_W-1-x) +: 8];
         case (c)
            8'h23:        r[2*x +: 2] = WALL;
            8'h2E, 8'h6F: r[2*x +: 2] = WKRP;
            8'h47:        r[2*x +: 2] = WKGH;
            default:      r[2*x +: 2] = WKNP;
         endcase
      end
      return r;
   endfunction

   // Row text selection; the leftmost character is tile x=0.
   always_comb begin
      w_text = "############################";
      case (i_row)
         5'd1, 5'd20:               w_text = "#............##............#";
         5'd2, 5'd4, 5'd21, 5'd22:  w_text = "#.####.#####.##.#####.####.#";
         5'd3:                      w_text = "#o####.#####.##.#####.####o#";
         5'd5, 5'd29:               w_text = "#..........................#";
         5'd6, 5'd7:                w_text = "#.####.##.########.##.####.#";
         5'd8, 5'd26:               w_text = "#......##....##....##......#";
         5'd9:                      w_text = "######.##### ## #####.######";
         5'd10:                     w_text = "     #.##### ## #####.#     ";
         5'd11, 5'd17:              w_text = "     #.##          ##.#     ";
         5'd12:                     w_text = "     #.## ###GG### ##.#     ";
         5'd13, 5'd15:              w_text = "######.## #GGGGGG# ##.######";
         5'd14:                     w_text = "      .   #GGGGGG#   .      ";
         5'd16, 5'd18:              w_text = "     #.## ######## ##.#     ";
         5'd19:                     w_text = "######.## ######## ##.######";
         5'd23:                     w_text = "#o..##.......  .......##..o#";
         5'd24, 5'd25:              w_text = "###.##.##.########.##.##.###";
         5'd27, 5'd28:              w_text = "#.##########.##.##########.#";
         default:                   w_text = "############################";
      endcase
      o_tiles = decode_row(w_text);
   end

endmodule

// File: rtl/maze_tiles.sv
// Live maze tile map for the pacman mover: loads the ROM row by row, answers
// neighbour queries, clears pellets under pacman and tracks score/level state.
module maze_tiles
   import maze_tiles_pkg::*;
#(
   parameter int TUNNEL_ROW = 14,
   parameter int PELLET_PTS = 10,
   parameter int SCORE_W    = 16
) (
   input  logic        clk60,
   input  logic        reset,
   maze_tiles_if.slave io_maze
);

   localparam logic [6:0] X_LIM  = 7'(MAZE_W);
   localparam logic [6:0] Y_LIM  = 7'(MAZE_H);
   localparam logic [4:0] LAST_X = 5'(MAZE_W - 1);
   localparam logic [4:0] LAST_Y = 5'(MAZE_H - 1);
   localparam logic [4:0] TUN_Y  = 5'(TUNNEL_ROW);

   game_state_t        r_state, w_state_nxt;
   logic [4:0]         r_row, w_row_nxt;
   maze_row_t          r_map [0:MAZE_H-1];
   maze_row_t          w_rom_row;
   maze_row_t          w_cur_row;
   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W:0]   w_score_sum;
   logic [7:0]         r_pellets;
   logic               r_eaten;
   logic [4:0]         w_cx, w_cy;
   logic               w_cur_ok, w_tunnel, w_eat;
   logic [1:0]         w_cur_tile;
   logic [1:0]         w_tile_info [0:3];

   maze_tiles_rom u_rom (
      .i_row   (r_row),
      .o_tiles (w_rom_row)
   );

   assign w_cx        = io_maze.curr_xtile[4:0];
   assign w_cy        = io_maze.curr_ytile[4:0];
   assign w_cur_ok    = (io_maze.curr_xtile < X_LIM) && (io_maze.curr_ytile < Y_LIM);
   assign w_tunnel    = (w_cy == TUN_Y);
   assign w_cur_row   = r_map[w_cy];
   assign w_cur_tile  = w_cur_row[{w_cx, 1'b0} +: 2];
   assign w_eat       = (r_state == GS_PLAY) && w_cur_ok && (w_cur_tile == WKRP) && !io_maze.restart;
   assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(PELLET_PTS);

   // Neighbour lookup; pacman is boxed in by walls while the map is loading.
   always_comb begin
      w_tile_info = '{WALL, WALL, WALL, WALL};
      if ((r_state != GS_LOAD) && w_cur_ok) begin
         if (w_cx != LAST_X) w_tile_info[0] = w_cur_row[{w_cx + 5'd1, 1'b0} +: 2];
         else if (w_tunnel)  w_tile_info[0] = w_cur_row[1:0];
         else                w_tile_info[0] = WALL;
         if (w_cy != 5'd0)   w_tile_info[1] = r_map[w_cy - 5'd1][{w_cx, 1'b0} +: 2];
         else                w_tile_info[1] = WALL;
         if (w_cy != LAST_Y) w_tile_info[2] = r_map[w_cy + 5'd1][{w_cx, 1'b0} +: 2];
         else                w_tile_info[2] = WALL;
         if (w_cx != 5'd0)   w_tile_info[3] = w_cur_row[{w_cx - 5'd1, 1'b0} +: 2];
         else if (w_tunnel)  w_tile_info[3] = w_cur_row[ROW_W-1 -: 2];
         else                w_tile_info[3] = WALL;
      end else begin
         w_tile_info = '{WALL, WALL, WALL, WALL};
      end
   end

   // Game-state sequencing: LOAD walks the rows, PLAY runs until the last pellet goes.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      case (r_state)
         GS_LOAD: begin
            if (io_maze.restart) begin
               w_row_nxt = 5'd0;
            end else if (r_row == LAST_Y) begin
               w_state_nxt = GS_PLAY;
               w_row_nxt   = 5'd0;
            end else begin
               w_row_nxt = r_row + 5'd1;
            end
         end
         GS_PLAY: begin
            if (io_maze.restart) begin
               w_state_nxt = GS_LOAD;
               w_row_nxt   = 5'd0;
            end else if (w_eat && (r_pellets <= 8'd1)) begin
               w_state_nxt = GS_CLEARED;
            end else begin
               w_state_nxt = GS_PLAY;
            end
         end
         GS_CLEARED: begin
            if (io_maze.restart) begin
               w_state_nxt = GS_LOAD;
               w_row_nxt   = 5'd0;
            end else begin
               w_state_nxt = GS_CLEARED;
            end
         end
         default: begin
            w_state_nxt = GS_LOAD;
            w_row_nxt   = 5'd0;
         end
      endcase
   end

   // State, score and pellet bookkeeping; restart always empties the pellet count.
   always_ff @(posedge clk60) begin
      if (reset) begin
         r_state   <= GS_LOAD;
         r_row     <= 5'd0;
         r_score   <= {SCORE_W{1'b0}};
         r_pellets <= 8'd0;
         r_eaten   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_eaten <= w_eat;
         if (w_eat) r_score <= w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
         else       r_score <= r_score;
         if (io_maze.restart)                      r_pellets <= 8'd0;
         else if (r_state == GS_LOAD)              r_pellets <= r_pellets + {2'b00, wkrp_count(w_rom_row)};
         else if (w_eat && (r_pellets != 8'd0))    r_pellets <= r_pellets - 8'd1;
         else                                      r_pellets <= r_pellets;
      end
   end

   // Live map: bulk row copy while loading, single-tile pellet clear while playing.
   always_ff @(posedge clk60) begin
      if (!reset && (r_state == GS_LOAD) && !io_maze.restart) begin
         r_map[r_row] <= w_rom_row;
      end else if (!reset && w_eat) begin
         r_map[w_cy][{w_cx, 1'b0} +: 2] <= WKNP;
      end
   end

   assign io_maze.tile_info    = w_tile_info;
   assign io_maze.ready        = (r_state != GS_LOAD);
   assign io_maze.level_clear  = (r_state == GS_CLEARED);
   assign io_maze.pellet_eaten = r_eaten;
   assign io_maze.score        = r_score;
   assign io_maze.pellets_left = r_pellets;

endmodule
